// File: rtl/alu_arbiter_ctrl.sv
// Shares one combinational ALU between two requesters, round robin, with one operation in flight.
// Grant to response takes 2 cycles. Requests wait outside IDLE, and RESP holds until the owner takes the result.
module alu_arbiter_ctrl #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 3,
   parameter int CNT_W  = 16
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r0_req_valid,
   output logic              r0_req_ready,
   input  logic [DATA_W-1:0] r0_req_a,
   input  logic [DATA_W-1:0] r0_req_b,
   input  logic [OP_W-1:0]   r0_req_op,
   output logic              r0_rsp_valid,
   input  logic              r0_rsp_ready,
   output logic [DATA_W-1:0] r0_rsp_data,
   input  logic              r1_req_valid,
   output logic              r1_req_ready,
   input  logic [DATA_W-1:0] r1_req_a,
   input  logic [DATA_W-1:0] r1_req_b,
   input  logic [OP_W-1:0]   r1_req_op,
   output logic              r1_rsp_valid,
   input  logic              r1_rsp_ready,
   output logic [DATA_W-1:0] r1_rsp_data,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_opcode,
   input  logic [DATA_W-1:0] alu_out,
   output logic              busy,
   output logic [CNT_W-1:0]  op_count
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [DATA_W-1:0] r_a, r_b, r_res;
   logic [OP_W-1:0]   r_op;
   logic              r_owner;
   logic              r_last_grant;
   logic [CNT_W-1:0]  r_count;

   logic w_grant_id;
   logic w_accept;
   logic w_rsp_hs;

   // The accept term is gated by rst_n so that req_ready reads 0 while reset is held.
   always_comb begin
      if (r0_req_valid && r1_req_valid)
         w_grant_id = ~r_last_grant;
      else
         w_grant_id = r1_req_valid;
      w_accept = rst_n && (r_state == S_IDLE) && (r0_req_valid || r1_req_valid);
      w_rsp_hs = (r_state == S_RESP) && (r_owner ? r1_rsp_ready : r0_rsp_ready);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next_state = S_EXEC;
         S_EXEC:  w_next_state = S_RESP;
         S_RESP:  if (w_rsp_hs) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      r0_req_ready = w_accept && !w_grant_id;
      r1_req_ready = w_accept &&  w_grant_id;
      r0_rsp_valid = (r_state == S_RESP) && !r_owner;
      r1_rsp_valid = (r_state == S_RESP) &&  r_owner;
      r0_rsp_data  = ((r_state == S_RESP) && !r_owner) ? r_res : '0;
      r1_rsp_data  = ((r_state == S_RESP) &&  r_owner) ? r_res : '0;
      busy         = (r_state != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a          <= '0;
         r_b          <= '0;
         r_op         <= '0;
         r_res        <= '0;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_count      <= '0;
      end else begin
         if (w_accept) begin
            r_a     <= w_grant_id ? r1_req_a  : r0_req_a;
            r_b     <= w_grant_id ? r1_req_b  : r0_req_b;
            r_op    <= w_grant_id ? r1_req_op : r0_req_op;
            r_owner <= w_grant_id;
         end
         if (r_state == S_EXEC)
            r_res <= alu_out;
         if (w_rsp_hs) begin
            r_last_grant <= r_owner;
            r_count      <= r_count + CNT_W'(1);
         end
      end
   end

   assign alu_a      = r_a;
   assign alu_b      = r_b;
   assign alu_opcode = r_op;
   assign op_count   = r_count;

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Bench for alu_arbiter_ctrl: directed scenarios plus a randomized run against a transaction-level model.
module tb_alu_arbiter_ctrl;
   localparam int DW = 8;
   localparam int OW = 3;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          r0_req_valid, r0_req_ready, r0_rsp_valid, r0_rsp_ready;
   logic [DW-1:0] r0_req_a, r0_req_b, r0_rsp_data;
   logic [OW-1:0] r0_req_op;
   logic          r1_req_valid, r1_req_ready, r1_rsp_valid, r1_rsp_ready;
   logic [DW-1:0] r1_req_a, r1_req_b, r1_rsp_data;
   logic [OW-1:0] r1_req_op;
   logic [DW-1:0] alu_a, alu_b, alu_out;
   logic [OW-1:0] alu_opcode;
   logic          busy;
   logic [CW-1:0] op_count;

   int n_chk  = 0;
   int n_fail = 0;
   int m_count = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return a << b[2:0];
         3'b011:  return a >> b[2:0];
         3'b100:  return a & b;
         3'b101:  return a | b;
         3'b110:  return a ^ b;
         default: return (a == b) ? 8'h01 : 8'h00;
      endcase
   endfunction

   assign alu_out = alu_f(alu_opcode, alu_a, alu_b);

   alu_arbiter_ctrl #(.DATA_W(DW), .OP_W(OW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_a(r0_req_a),
      .r0_req_b(r0_req_b), .r0_req_op(r0_req_op), .r0_rsp_valid(r0_rsp_valid),
      .r0_rsp_ready(r0_rsp_ready), .r0_rsp_data(r0_rsp_data),
      .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_a(r1_req_a),
      .r1_req_b(r1_req_b), .r1_req_op(r1_req_op), .r1_rsp_valid(r1_rsp_valid),
      .r1_rsp_ready(r1_rsp_ready), .r1_rsp_data(r1_rsp_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
      .busy(busy), .op_count(op_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      r0_req_valid = 0; r0_req_a = '0; r0_req_b = '0; r0_req_op = '0; r0_rsp_ready = 0;
      r1_req_valid = 0; r1_req_a = '0; r1_req_b = '0; r1_req_op = '0; r1_rsp_ready = 0;
   endtask

   task automatic set_r0(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      r0_req_valid = 1; r0_req_op = op; r0_req_a = a; r0_req_b = b;
   endtask

   task automatic set_r1(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      r1_req_valid = 1; r1_req_op = op; r1_req_a = a; r1_req_b = b;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
      m_count = 0;
   endtask

   task automatic test_reset();
      r0_req_valid = 1; r1_req_valid = 1;
      #3;
      n_chk++;
      if ({r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid, busy} !== 5'b0) begin
         n_fail++; $display("FAIL reset_ctrl got=%b exp=00000", {r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid, busy});
      end
      n_chk++;
      if ({r0_rsp_data, r1_rsp_data, alu_a, alu_b, alu_opcode, op_count} !== '0) begin
         n_fail++; $display("FAIL reset_data got=%h exp=0", {r0_rsp_data, r1_rsp_data, alu_a, alu_b, alu_opcode, op_count});
      end
      idle_inputs();
      tick();
      rst_n = 1;
      m_count = 0;
   endtask

   task automatic test_single();
      set_r0(3'b000, 8'h0F, 8'h01);
      r0_rsp_ready = 1;
      @(negedge clk);
      n_chk++;
      if ({r0_req_ready, r1_req_ready, busy} !== 3'b100) begin
         n_fail++; $display("FAIL single_accept got=%b exp=100", {r0_req_ready, r1_req_ready, busy});
      end
      tick();
      r0_req_valid = 0;
      @(negedge clk);
      n_chk++;
      if ({busy, r0_rsp_valid, r1_rsp_valid} !== 3'b100) begin
         n_fail++; $display("FAIL single_exec got=%b exp=100", {busy, r0_rsp_valid, r1_rsp_valid});
      end
      n_chk++;
      if ({alu_a, alu_b, alu_opcode} !== {8'h0F, 8'h01, 3'b000}) begin
         n_fail++; $display("FAIL single_alu got=%h/%h/%h exp=0f/01/0", alu_a, alu_b, alu_opcode);
      end
      tick();
      @(negedge clk);
      n_chk++;
      if ({r0_rsp_valid, r1_rsp_valid, r0_rsp_data, r1_rsp_data} !== {2'b10, 8'h10, 8'h00}) begin
         n_fail++; $display("FAIL single_resp got=%b%b %h %h exp=10 10 00", r0_rsp_valid, r1_rsp_valid, r0_rsp_data, r1_rsp_data);
      end
      tick();
      m_count++;
      @(negedge clk);
      n_chk++;
      if ({busy, r0_rsp_valid, op_count} !== {2'b00, CW'(m_count)}) begin
         n_fail++; $display("FAIL single_done got=%b%b cnt=%0d exp=00 cnt=%0d", busy, r0_rsp_valid, op_count, m_count);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_wrap_shift();
      logic [2:0] t_op[3];
      logic [7:0] t_a[3], t_b[3], t_exp[3];
      t_op = '{3'b001, 3'b010, 3'b111};
      t_a  = '{8'h00, 8'h81, 8'h5A};
      t_b  = '{8'h01, 8'hF9, 8'h5A};
      t_exp = '{8'hFF, 8'h02, 8'h01};
      r1_rsp_ready = 1;
      for (int i = 0; i < 3; i++) begin
         set_r1(t_op[i], t_a[i], t_b[i]);
         @(negedge clk);
         n_chk++;
         if ({r0_req_ready, r1_req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL wrap_accept%0d got=%b exp=01", i, {r0_req_ready, r1_req_ready});
         end
         tick();
         r1_req_valid = 0;
         tick();
         @(negedge clk);
         n_chk++;
         if ({r1_rsp_valid, r1_rsp_data} !== {1'b1, t_exp[i]}) begin
            n_fail++; $display("FAIL wrap_resp%0d got=%b/%h exp=1/%h", i, r1_rsp_valid, r1_rsp_data, t_exp[i]);
         end
         tick();
         m_count++;
      end
      @(negedge clk);
      n_chk++;
      if (op_count !== CW'(m_count)) begin
         n_fail++; $display("FAIL wrap_count got=%0d exp=%0d", op_count, m_count);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_contention();
      do_reset();
      set_r0(3'b110, 8'hF0, 8'h0F);
      set_r1(3'b100, 8'hF0, 8'h0F);
      r0_rsp_ready = 1; r1_rsp_ready = 1;
      @(negedge clk);
      n_chk++;
      if ({r0_req_ready, r1_req_ready} !== 2'b10) begin
         n_fail++; $display("FAIL cont_first got=%b exp=10", {r0_req_ready, r1_req_ready});
      end
      tick();
      r0_req_valid = 0;
      @(negedge clk);
      n_chk++;
      if (r1_req_ready !== 1'b0) begin
         n_fail++; $display("FAIL cont_holdoff got=%b exp=0", r1_req_ready);
      end
      tick();
      @(negedge clk);
      n_chk++;
      if ({r0_rsp_valid, r0_rsp_data, r1_req_ready} !== {1'b1, 8'hFF, 1'b0}) begin
         n_fail++; $display("FAIL cont_r0_resp got=%b/%h/%b exp=1/ff/0", r0_rsp_valid, r0_rsp_data, r1_req_ready);
      end
      tick();
      m_count++;
      @(negedge clk);
      n_chk++;
      if ({r0_req_ready, r1_req_ready} !== 2'b01) begin
         n_fail++; $display("FAIL cont_second got=%b exp=01", {r0_req_ready, r1_req_ready});
      end
      tick();
      r1_req_valid = 0;
      tick();
      @(negedge clk);
      n_chk++;
      if ({r1_rsp_valid, r1_rsp_data} !== {1'b1, 8'h00}) begin
         n_fail++; $display("FAIL cont_r1_resp got=%b/%h exp=1/00", r1_rsp_valid, r1_rsp_data);
      end
      tick();
      m_count++;
      // both held valid continuously: grants must alternate starting with r0
      r0_req_valid = 1; r1_req_valid = 1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_chk++;
         if ({r0_req_ready, r1_req_ready} !== ((k % 2) ? 2'b01 : 2'b10)) begin
            n_fail++; $display("FAIL alt_grant%0d got=%b exp=%b", k, {r0_req_ready, r1_req_ready}, ((k % 2) ? 2'b01 : 2'b10));
         end
         tick();
         tick();
         @(negedge clk);
         n_chk++;
         if ({r0_rsp_valid, r1_rsp_valid, r0_rsp_data, r1_rsp_data} !== ((k % 2) ? {2'b01, 8'h00, 8'h00} : {2'b10, 8'hFF, 8'h00})) begin
            n_fail++; $display("FAIL alt_resp%0d got=%b%b %h %h", k, r0_rsp_valid, r1_rsp_valid, r0_rsp_data, r1_rsp_data);
         end
         tick();
         m_count++;
      end
      r0_req_valid = 0; r1_req_valid = 0;
      @(negedge clk);
      n_chk++;
      if (op_count !== CW'(m_count)) begin
         n_fail++; $display("FAIL cont_count got=%0d exp=%0d", op_count, m_count);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_backpressure();
      set_r0(3'b101, 8'h30, 8'h03);
      r1_rsp_ready = 1;
      @(negedge clk);
      n_chk++;
      if (r0_req_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_accept got=%b exp=1", r0_req_ready);
      end
      tick();
      r0_req_valid = 0;
      set_r1(3'b000, 8'h01, 8'h02);
      @(negedge clk);
      n_chk++;
      if (r1_req_ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_exec_hold got=%b exp=0", r1_req_ready);
      end
      tick();
      for (int i = 0; i < 6; i++) begin
         if (i == 5) r0_rsp_ready = 1;
         @(negedge clk);
         n_chk++;
         if ({r0_rsp_valid, r0_rsp_data, r1_req_ready, r1_rsp_valid} !== {1'b1, 8'h33, 2'b00}) begin
            n_fail++; $display("FAIL bp_hold%0d got=%b/%h/%b/%b exp=1/33/0/0", i, r0_rsp_valid, r0_rsp_data, r1_req_ready, r1_rsp_valid);
         end
         tick();
      end
      m_count++;
      @(negedge clk);
      n_chk++;
      if ({r1_req_ready, r0_rsp_valid} !== 2'b10) begin
         n_fail++; $display("FAIL bp_next_grant got=%b exp=10", {r1_req_ready, r0_rsp_valid});
      end
      tick();
      r1_req_valid = 0;
      tick();
      @(negedge clk);
      n_chk++;
      if ({r1_rsp_valid, r1_rsp_data} !== {1'b1, 8'h03}) begin
         n_fail++; $display("FAIL bp_r1_resp got=%b/%h exp=1/03", r1_rsp_valid, r1_rsp_data);
      end
      tick();
      m_count++;
      idle_inputs();
   endtask

   task automatic test_reset_midop();
      set_r0(3'b100, 8'hAA, 8'h0F);
      tick();
      r0_req_valid = 0;
      tick();
      @(negedge clk);
      n_chk++;
      if ({r0_rsp_valid, r0_rsp_data} !== {1'b1, 8'h0A}) begin
         n_fail++; $display("FAIL mid_pre got=%b/%h exp=1/0a", r0_rsp_valid, r0_rsp_data);
      end
      rst_n = 0;
      r0_req_valid = 1; r1_req_valid = 1;
      #1;
      n_chk++;
      if ({r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid, busy, r0_rsp_data, alu_a, op_count} !== '0) begin
         n_fail++; $display("FAIL mid_reset_outs got=%b %h %h %0d", {r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid, busy}, r0_rsp_data, alu_a, op_count);
      end
      tick();
      tick();
      rst_n = 1;
      m_count = 0;
      r0_rsp_ready = 1;
      @(negedge clk);
      n_chk++;
      if ({r0_rsp_valid, r1_rsp_valid, op_count} !== {2'b00, CW'(0)}) begin
         n_fail++; $display("FAIL mid_after got=%b%b cnt=%0d exp=00 cnt=0", r0_rsp_valid, r1_rsp_valid, op_count);
      end
      n_chk++;
      if ({r0_req_ready, r1_req_ready} !== 2'b10) begin
         n_fail++; $display("FAIL mid_first_grant got=%b exp=10", {r0_req_ready, r1_req_ready});
      end
      tick();
      r0_req_valid = 0; r1_req_valid = 0;
      tick();
      tick();
      m_count++;
      idle_inputs();
   endtask

   task automatic test_count_wrap();
      do_reset();
      set_r0(3'b000, 8'h01, 8'h01);
      r0_rsp_ready = 1;
      for (int i = 0; i < 17; i++) begin
         tick();
         tick();
         tick();
         m_count++;
         if (i == 15) begin
            @(negedge clk);
            n_chk++;
            if (op_count !== CW'(0)) begin
               n_fail++; $display("FAIL cnt_wrap16 got=%0d exp=0", op_count);
            end
         end
      end
      r0_req_valid = 0;
      @(negedge clk);
      n_chk++;
      if (op_count !== CW'(1)) begin
         n_fail++; $display("FAIL cnt_wrap17 got=%0d exp=1", op_count);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_random();
      logic       v[2];
      logic [7:0] ra[2], rb[2];
      logic [2:0] rop[2];
      logic       act, own, m_last, rdy0, rdy1, ev0, ev1, hs;
      int         age;
      logic [7:0] exp_data;
      do_reset();
      v = '{0, 0}; act = 0; own = 0; age = 0; m_last = 1; exp_data = '0;
      ra = '{8'h00, 8'h00}; rb = '{8'h00, 8'h00}; rop = '{3'b000, 3'b000};
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         rdy0 = !act && v[0] && (!v[1] || m_last);
         rdy1 = !act && v[1] && (!v[0] || !m_last);
         ev0  = act && age >= 2 && !own;
         ev1  = act && age >= 2 &&  own;
         n_chk++;
         if ({r0_req_ready, r1_req_ready} !== {rdy0, rdy1}) begin
            n_fail++; $display("FAIL rand_ready c=%0d got=%b exp=%b%b", c, {r0_req_ready, r1_req_ready}, rdy0, rdy1);
         end
         n_chk++;
         if ({r0_rsp_valid, r1_rsp_valid} !== {ev0, ev1}) begin
            n_fail++; $display("FAIL rand_rsp_valid c=%0d got=%b exp=%b%b", c, {r0_rsp_valid, r1_rsp_valid}, ev0, ev1);
         end
         n_chk++;
         if ({r0_rsp_data, r1_rsp_data} !== {(ev0 ? exp_data : 8'h00), (ev1 ? exp_data : 8'h00)}) begin
            n_fail++; $display("FAIL rand_rsp_data c=%0d got=%h %h exp=%h", c, r0_rsp_data, r1_rsp_data, exp_data);
         end
         n_chk++;
         if ({busy, op_count} !== {act, CW'(m_count)}) begin
            n_fail++; $display("FAIL rand_busy_cnt c=%0d got=%b/%0d exp=%b/%0d", c, busy, op_count, act, m_count);
         end
         hs = act && age >= 2 && (own ? r1_rsp_ready : r0_rsp_ready);
         tick();
         if (act) begin
            if (hs) begin
               act = 0; m_last = own; m_count++;
            end else begin
               age++;
            end
         end
         if (rdy0 || rdy1) begin
            act = 1; own = rdy1; age = 1;
            exp_data = alu_f(rop[own], ra[own], rb[own]);
            v[own] = 0;
         end
         for (int r = 0; r < 2; r++) begin
            if (!v[r] && $urandom_range(1, 0) == 1) begin
               v[r] = 1;
               ra[r] = 8'($urandom);
               rb[r] = 8'($urandom);
               rop[r] = 3'($urandom);
            end
         end
         r0_req_valid = v[0]; r0_req_a = ra[0]; r0_req_b = rb[0]; r0_req_op = rop[0];
         r1_req_valid = v[1]; r1_req_a = ra[1]; r1_req_b = rb[1]; r1_req_op = rop[1];
         r0_rsp_ready = 1'($urandom_range(1, 0));
         r1_rsp_ready = 1'($urandom_range(1, 0));
      end
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached, checks=%0d", n_chk);
      $fatal(1, "timeout");
   end

   initial begin
      idle_inputs();
      #2 rst_n = 0;
      test_reset();
      test_single();
      test_wrap_shift();
      test_contention();
      test_backpressure();
      test_reset_midop();
      test_count_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter_ctrl.md
Name: alu_arbiter_ctrl

Overview:
Arbitration and sequencing controller that shares one 8-bit ALU (opcodes 000 ADD, 001 SUB, 010 SLL by b[2:0], 011 SRL by b[2:0], 100 AND, 101 OR, 110 XOR, 111 EQL) between two requesters. Each requester issues operations over a valid/ready request channel and collects results over a valid/ready response channel. The block registers operands, drives the ALU from those registers, captures the ALU result, and returns it to the owning requester. It sits between client logic and the ALU, which stays purely combinational.

Parameters:
DATA_W, 8, operand/result width; must match the ALU.
OP_W, 3, opcode width.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
r0_req_valid  input  1  requester 0 has an operation.
r0_req_ready  output  1  requester 0 operation accepted this cycle.
r0_req_a  input  DATA_W  requester 0 operand a.
r0_req_b  input  DATA_W  requester 0 operand b.
r0_req_op  input  OP_W  requester 0 opcode.
r0_rsp_valid  output  1  result available for requester 0.
r0_rsp_ready  input  1  requester 0 takes the result.
r0_rsp_data  output  DATA_W  result for requester 0.
r1_req_valid, r1_req_ready, r1_req_a, r1_req_b, r1_req_op, r1_rsp_valid, r1_rsp_ready, r1_rsp_data  same directions, widths and meanings, for requester 1.
alu_a  output  DATA_W  ALU operand a.
alu_b  output  DATA_W  ALU operand b.
alu_opcode  output  OP_W  ALU opcode.
alu_out  input  DATA_W  ALU result (combinational from alu_a/alu_b/alu_opcode).
busy  output  1  high whenever state is not IDLE.
op_count  output  CNT_W  number of completed response handshakes.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; a_reg, b_reg, op_reg, res_reg = 0; owner = 0; last_grant = 1, so requester 0 wins the first contention; op_count = 0. All outputs reset to 0: req_ready, rsp_valid, rsp_data, alu_*, busy.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE, arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester not equal to last_grant (round robin).
  - Neither valid: stay in IDLE.
- IDLE, grant: the granted rX_req_ready is asserted combinationally in the same cycle (state==IDLE && grant). On that edge, a/b/op are captured into a_reg/b_reg/op_reg, owner is set to the granted requester, and the FSM moves to EXEC.
- rX_req_ready is never asserted outside IDLE. Never both in the same cycle.
- alu_a/alu_b/alu_opcode are driven continuously from a_reg/b_reg/op_reg. They are stable for the whole of EXEC.
- EXEC: lasts exactly one cycle. res_reg <= alu_out at the end of the cycle, then go to RESP.
- RESP:
  - r<owner>_rsp_valid = 1 and r<owner>_rsp_data = res_reg. The other requester's rsp_valid stays 0 and its rsp_data holds 0.
  - The FSM holds in RESP, with data stable, until r<owner>_rsp_ready = 1.
  - On the handshake edge: last_grant <= owner, op_count increments (wrapping at 2^CNT_W-1 -> 0), and the FSM returns to IDLE.
- Latency: request accepted at edge N -> rsp_valid high from cycle N+2. Minimum 3 cycles per operation. No overlap: a new grant happens only in IDLE.
- A requester's valid seen during EXEC/RESP is held off (req_ready = 0). Requesters must keep valid and payload stable until ready.
- rsp_ready from the non-owner is ignored. rsp_ready asserted early, before RESP, has no effect.
- Arithmetic and width behaviour is set by the ALU:
  - ADD/SUB wrap modulo 2^DATA_W.
  - Shifts use b[2:0] only.
  - EQL returns 8'h01 or 8'h00.
  - The controller does no arithmetic on data.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded, no response is produced, and op_count is cleared.
- busy = (state != IDLE).

Test Plan:
- Single op: r0 ADD a=8'h0F b=8'h01, r0_rsp_ready=1 -> r0_req_ready in accept cycle; r0_rsp_valid two cycles later with 8'h10; op_count=1.
- Wrap/shift: r1 SUB 8'h00-8'h01 -> 8'hFF; r1 SLL a=8'h81 b=8'hF9 (shift 1) -> 8'h02; r1 EQL 8'h5A,8'h5A -> 8'h01.
- Contention: both valid from reset (r0 XOR 8'hF0^8'h0F, r1 AND 8'hF0&8'h0F) -> r0 served first (8'hFF), then r1 (8'h00). Both held valid continuously -> grants alternate r0,r1,r0,r1.
- Back-pressure: r0 OR 8'h30|8'h03 with r0_rsp_ready low for 5 cycles -> rsp_valid/rsp_data=8'h33 held stable; r1_req_ready stays 0 throughout; r1 granted in the IDLE cycle after the handshake.
- Reset mid-op: deassert rst_n while in RESP -> all outputs 0 immediately; after release, no stale rsp_valid; op_count=0; next contention grants r0.
- Counter wrap: with CNT_W=4, complete 17 ops -> op_count reads 1.
